vram_frame_writer: RTL and testbench

- Write-side master for port A of the dual-port 480x272x9 video RAM. The display scan logic on tft_clk reads the opposite port.
- Converts touch draw requests and clear-screen requests into registered write enable, address and data on the cclk domain.
- A clear sweeps every pixel address, one write per cycle, and reports completion.

---
 rtl/vram_frame_writer.sv | 166 ++++++++++++++++
 tb/tb_vram_frame_writer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_frame_writer.sv
// Port-A write master for the dual-port video RAM: single-pixel draws and full-frame clears.
// Define VRAM_FRAME_WRITER_BRUSH3_EN to paint a 3x3 brush around each accepted draw point.
module vram_frame_writer #(
   parameter int H_RES      = 480,
   parameter int V_RES      = 272,
   parameter int COLOR_BITS = 9,
   parameter int ADDR_BITS  = 17
) (
   input  logic                  cclk,
   input  logic                  rst,
   input  logic                  draw_req,
   input  logic [11:0]           draw_x,
   input  logic [11:0]           draw_y,
   input  logic [COLOR_BITS-1:0] draw_color,
   input  logic                  clear_req,
   input  logic [COLOR_BITS-1:0] clear_color,
   output logic                  wr_ena,
   output logic [ADDR_BITS-1:0]  wr_addr,
   output logic [COLOR_BITS-1:0] wr_data,
   output logic                  busy,
   output logic                  clear_done
);

   localparam int NPIX     = H_RES * V_RES;
   // One spare bit so the sweep counter can hold NPIX even when NPIX == 2**ADDR_BITS.
   localparam int CNT_BITS = ADDR_BITS + 1;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      BRUSH
   } state_t;

   state_t              state;
   logic                clear_q;
   logic [CNT_BITS-1:0] clr_cnt;
   logic                clear_edge;
   logic                draw_ok;

   assign clear_edge = clear_req & ~clear_q;
   assign draw_ok    = draw_req && (32'(draw_x) < 32'(H_RES)) && (32'(draw_y) < 32'(V_RES));

`ifdef VRAM_FRAME_WRITER_BRUSH3_EN
   typedef struct packed {
      logic                 ok;
      logic [ADDR_BITS-1:0] addr;
   } pix_t;

   logic [11:0]           brush_x;
   logic [11:0]           brush_y;
   logic [COLOR_BITS-1:0] brush_color;
   logic [3:0]            step;
   pix_t                  pix_first;
   pix_t                  pix_next;

   // Step s visits (x + s%3 - 1, y + s/3 - 1); off-frame neighbours are flagged, not wrapped.
   function automatic pix_t brush_pix(input logic [11:0] cx, input logic [11:0] cy,
                                      input logic [3:0] s);
      int   px;
      int   py;
      pix_t p;
      px     = int'(cx) + int'(s) % 3 - 1;
      py     = int'(cy) + int'(s) / 3 - 1;
      p.ok   = (px >= 0) && (px < H_RES) && (py >= 0) && (py < V_RES);
      p.addr = ADDR_BITS'(py * H_RES + px);
      return p;
   endfunction

   assign pix_first = brush_pix(draw_x, draw_y, 4'd0);
   assign pix_next  = brush_pix(brush_x, brush_y, step);
`else
   logic [ADDR_BITS-1:0] draw_addr;

   assign draw_addr = ADDR_BITS'(32'(draw_y) * 32'(H_RES) + 32'(draw_x));
`endif

   // NOTE: all state here is updated with <= so clear_edge always compares against the
   // previous cycle's clear_req, regardless of statement order inside the block.
   always_ff @(posedge cclk) begin
      if (rst) begin
         state       <= IDLE;
         clear_q     <= 1'b0;
         clr_cnt     <= '0;
         wr_ena      <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         busy        <= 1'b0;
         clear_done  <= 1'b0;
`ifdef VRAM_FRAME_WRITER_BRUSH3_EN
         brush_x     <= '0;
         brush_y     <= '0;
         brush_color <= '0;
         step        <= '0;
`endif
      end else begin
         clear_q <= clear_req;
         case (state)
            IDLE: begin
               if (clear_edge) begin
                  // wr_data holds the fill colour for the whole sweep.
                  state      <= CLEAR;
                  clr_cnt    <= CNT_BITS'(1);
                  wr_ena     <= 1'b1;
                  wr_addr    <= '0;
                  wr_data    <= clear_color;
                  busy       <= 1'b1;
                  clear_done <= 1'b0;
               end else if (draw_ok) begin
`ifdef VRAM_FRAME_WRITER_BRUSH3_EN
                  state       <= BRUSH;
                  brush_x     <= draw_x;
                  brush_y     <= draw_y;
                  brush_color <= draw_color;
                  step        <= 4'd1;
                  wr_ena      <= pix_first.ok;
                  wr_addr     <= pix_first.addr;
                  wr_data     <= draw_color;
                  busy        <= 1'b1;
`else
                  wr_ena  <= 1'b1;
                  wr_addr <= draw_addr;
                  wr_data <= draw_color;
`endif
               end else begin
                  wr_ena <= 1'b0;
               end
            end

            CLEAR: begin
               if (clr_cnt == CNT_BITS'(NPIX)) begin
                  state      <= IDLE;
                  wr_ena     <= 1'b0;
                  busy       <= 1'b0;
                  clear_done <= 1'b1;
               end else begin
                  wr_ena  <= 1'b1;
                  wr_addr <= clr_cnt[ADDR_BITS-1:0];
                  clr_cnt <= clr_cnt + CNT_BITS'(1);
               end
            end

`ifdef VRAM_FRAME_WRITER_BRUSH3_EN
            BRUSH: begin
               if (step == 4'd9) begin
                  state  <= IDLE;
                  wr_ena <= 1'b0;
                  busy   <= 1'b0;
               end else begin
                  wr_ena  <= pix_next.ok;
                  wr_addr <= pix_next.addr;
                  wr_data <= brush_color;
                  step    <= step + 4'd1;
               end
            end
`endif

            default: begin
               state  <= IDLE;
               wr_ena <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_frame_writer.sv
// Bench for vram_frame_writer: default-size instance for address/boundary vectors and
// a small-frame instance for full clear sweeps checked against a write-queue model.
module tb_vram_frame_writer;

   localparam int SH    = 20;
   localparam int SV    = 12;
   localparam int SA    = 8;
   localparam int SN    = SH * SV;
   localparam int S_HIT = 5 * SH + 5;

   logic cclk;

   // Default-size instance
   logic        b_rst, b_draw_req, b_clr;
   logic [11:0] b_x, b_y;
   logic [8:0]  b_color, b_clr_color;
   logic        b_wr_ena, b_busy, b_done;
   logic [16:0] b_wr_addr;
   logic [8:0]  b_wr_data;

   // Small-frame instance
   logic        s_rst, s_draw_req, s_clr;
   logic [11:0] s_x, s_y;
   logic [8:0]  s_color, s_clr_color;
   logic        s_wr_ena, s_busy, s_done;
   logic [SA-1:0] s_wr_addr;
   logic [8:0]  s_wr_data;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;
   int s_wr_cnt, s_busy_cnt, s_hit_cnt;

   vram_frame_writer u_big (
      .cclk(cclk), .rst(b_rst), .draw_req(b_draw_req), .draw_x(b_x), .draw_y(b_y),
      .draw_color(b_color), .clear_req(b_clr), .clear_color(b_clr_color),
      .wr_ena(b_wr_ena), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .busy(b_busy), .clear_done(b_done)
   );

   vram_frame_writer #(.H_RES(SH), .V_RES(SV), .COLOR_BITS(9), .ADDR_BITS(SA)) u_small (
      .cclk(cclk), .rst(s_rst), .draw_req(s_draw_req), .draw_x(s_x), .draw_y(s_y),
      .draw_color(s_color), .clear_req(s_clr), .clear_color(s_clr_color),
      .wr_ena(s_wr_ena), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .busy(s_busy), .clear_done(s_done)
   );

   initial cclk = 1'b0;
   always #5 cclk = ~cclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model for the small instance: every accepted request becomes a list of
   // future write-port cycles; busy lasts exactly as long as that list is being replayed.
   typedef struct packed {
      logic          ena;
      logic [SA-1:0] addr;
      logic [8:0]    data;
   } wr_t;

   wr_t           mq[$];
   logic          m_busy, m_done, m_ena, m_prev, m_clearing;
   logic [SA-1:0] m_addr;
   logic [8:0]    m_data;

   always @(posedge cclk) begin : model
      wr_t  w;
      logic edge_c;
      logic take;
      int   px, py;
      if (s_rst) begin
         mq.delete();
         m_busy = 0; m_done = 0; m_ena = 0; m_addr = '0; m_data = '0;
         m_prev = 0; m_clearing = 0;
      end else begin
         edge_c = s_clr && !m_prev;
         m_prev = s_clr;
         take   = 0;
         if (m_busy) begin
            if (mq.size() > 0) take = 1;
            else begin
               m_busy = 0;
               m_ena  = 0;
               if (m_clearing) m_done = 1;
            end
         end else if (edge_c) begin
            for (int a = 0; a < SN; a++) begin
               w.ena = 1'b1; w.addr = SA'(a); w.data = s_clr_color;
               mq.push_back(w);
            end
            m_clearing = 1; m_done = 0; m_busy = 1; take = 1;
         end else if (s_draw_req && s_x < SH && s_y < SV) begin
`ifdef VRAM_FRAME_WRITER_BRUSH3_EN
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  px = int'(s_x) + dx;
                  py = int'(s_y) + dy;
                  w.ena  = (px >= 0 && px < SH && py >= 0 && py < SV);
                  w.addr = w.ena ? SA'(py * SH + px) : '0;
                  w.data = s_color;
                  mq.push_back(w);
               end
            end
            m_clearing = 0; m_busy = 1; take = 1;
`else
            m_ena  = 1;
            m_addr = SA'(int'(s_y) * SH + int'(s_x));
            m_data = s_color;
`endif
         end else begin
            m_ena = 0;
         end
         if (take) begin
            w = mq.pop_front();
            m_ena = w.ena; m_addr = w.addr; m_data = w.data;
         end
      end
   end

   always @(posedge cclk) begin : small_checker
      #1;
      if (chk_en) begin
         check("small_ctrl", 32'({s_wr_ena, s_busy, s_done}), 32'({m_ena, m_busy, m_done}));
         if (m_ena)
            check("small_wr", 32'({s_wr_addr, s_wr_data}), 32'({m_addr, m_data}));
         if (s_wr_ena) s_wr_cnt++;
         if (s_busy) s_busy_cnt++;
         if (s_wr_ena && s_wr_addr == SA'(S_HIT)) s_hit_cnt++;
      end
   end

   typedef struct {
      logic        draw;
      logic [11:0] x, y;
      logic [8:0]  color;
      logic        e_ena;
      logic [16:0] e_addr;
      logic        e_busy;
      logic        n_ena;
      logic [16:0] n_addr;
   } vec_t;

   vec_t tbl[8];
   int   nb, nw;
   logic [16:0] got[4];
   logic [16:0] brush_exp[4];

   initial begin
      b_rst = 1; b_draw_req = 0; b_clr = 0; b_x = '0; b_y = '0; b_color = '0; b_clr_color = '0;
      s_rst = 1; s_draw_req = 0; s_clr = 0; s_x = '0; s_y = '0; s_color = '0; s_clr_color = '0;
      s_wr_cnt = 0; s_busy_cnt = 0; s_hit_cnt = 0;

`ifdef VRAM_FRAME_WRITER_BRUSH3_EN
      tbl[0] = '{1'b1, 12'd10,   12'd2,   9'h1C0, 1'b1, 17'd489,    1'b1, 1'b1, 17'd490};
      tbl[1] = '{1'b1, 12'd480,  12'd0,   9'h0F0, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[2] = '{1'b1, 12'd0,    12'd272, 9'h0F0, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[3] = '{1'b1, 12'd479,  12'd271, 9'h0AA, 1'b1, 17'd130078, 1'b1, 1'b1, 17'd130079};
      tbl[4] = '{1'b1, 12'd0,    12'd0,   9'h1FF, 1'b0, 17'd0,      1'b1, 1'b0, 17'd0};
      tbl[5] = '{1'b1, 12'd4095, 12'd4095,9'h001, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[6] = '{1'b0, 12'd7,    12'd7,   9'h123, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[7] = '{1'b1, 12'd479,  12'd0,   9'h055, 1'b0, 17'd0,      1'b1, 1'b0, 17'd0};
`else
      tbl[0] = '{1'b1, 12'd10,   12'd2,   9'h1C0, 1'b1, 17'd970,    1'b0, 1'b0, 17'd0};
      tbl[1] = '{1'b1, 12'd480,  12'd0,   9'h0F0, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[2] = '{1'b1, 12'd0,    12'd272, 9'h0F0, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[3] = '{1'b1, 12'd479,  12'd271, 9'h0AA, 1'b1, 17'd130559, 1'b0, 1'b0, 17'd0};
      tbl[4] = '{1'b1, 12'd0,    12'd0,   9'h1FF, 1'b1, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[5] = '{1'b1, 12'd4095, 12'd4095,9'h001, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[6] = '{1'b0, 12'd7,    12'd7,   9'h123, 1'b0, 17'd0,      1'b0, 1'b0, 17'd0};
      tbl[7] = '{1'b1, 12'd479,  12'd0,   9'h055, 1'b1, 17'd479,    1'b0, 1'b0, 17'd0};
`endif

      @(negedge cclk);
      chk_en = 1'b1;
      @(negedge cclk);
      check("rst_wr_ena",  32'(b_wr_ena),  32'(0));
      check("rst_wr_addr", 32'(b_wr_addr), 32'(0));
      check("rst_wr_data", 32'(b_wr_data), 32'(0));
      check("rst_busy",    32'(b_busy),    32'(0));
      check("rst_done",    32'(b_done),    32'(0));
      b_rst = 0;
      s_rst = 0;
      repeat (2) @(negedge cclk);

      // Single-cycle draw vectors on the full-size frame
      for (int i = 0; i < 8; i++) begin
         b_draw_req = tbl[i].draw; b_x = tbl[i].x; b_y = tbl[i].y; b_color = tbl[i].color;
         @(negedge cclk);
         b_draw_req = 1'b0;
         check($sformatf("tbl%0d_ena", i),  32'(b_wr_ena), 32'(tbl[i].e_ena));
         check($sformatf("tbl%0d_busy", i), 32'(b_busy),   32'(tbl[i].e_busy));
         if (tbl[i].e_ena)
            check($sformatf("tbl%0d_wr", i), 32'({b_wr_addr, b_wr_data}),
                  32'({tbl[i].e_addr, tbl[i].color}));
         @(negedge cclk);
         check($sformatf("tbl%0d_next_ena", i), 32'(b_wr_ena), 32'(tbl[i].n_ena));
         if (tbl[i].n_ena)
            check($sformatf("tbl%0d_next_addr", i), 32'(b_wr_addr), 32'(tbl[i].n_addr));
         repeat (12) @(negedge cclk);
      end

`ifdef VRAM_FRAME_WRITER_BRUSH3_EN
      // Brush at the frame corner with a competing draw held during the stroke
      brush_exp[0] = 17'd0; brush_exp[1] = 17'd1; brush_exp[2] = 17'd480; brush_exp[3] = 17'd481;
      b_draw_req = 1; b_x = 0; b_y = 0; b_color = 9'h0F0;
      nb = 0; nw = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge cclk);
         if (c == 0) begin b_x = 12'd100; b_y = 12'd100; end
         if (c == 5) b_draw_req = 1'b0;
         if (b_busy) nb++;
         if (b_wr_ena) begin
            if (nw < 4) got[nw] = b_wr_addr;
            nw++;
         end
      end
      check("brush_busy_cycles", 32'(nb), 32'(9));
      check("brush_write_count", 32'(nw), 32'(4));
      for (int i = 0; i < 4; i++)
         if (i < nw) check($sformatf("brush_addr%0d", i), 32'(got[i]), 32'(brush_exp[i]));
      repeat (4) @(negedge cclk);
`else
      // Held draw: one write per cycle following the moving point
      b_draw_req = 1; b_y = 12'd1; b_color = 9'h03C;
      for (int i = 0; i < 3; i++) begin
         b_x = 12'(i + 1);
         @(negedge cclk);
         check($sformatf("held_draw%0d", i), 32'({b_wr_ena, b_wr_addr}), 32'({1'b1, 17'(481 + i)}));
      end
      b_draw_req = 0;
      @(negedge cclk);
      check("held_draw_release", 32'(b_wr_ena), 32'(0));
      repeat (2) @(negedge cclk);
`endif

      // Clear edge together with a draw at (0,0): sweep only, then reset at address 1000
      b_clr = 1; b_clr_color = 9'h007; b_draw_req = 1; b_x = 0; b_y = 0; b_color = 9'h155;
      @(negedge cclk);
      b_clr = 0; b_draw_req = 0; b_clr_color = 9'h1AA;
      check("sweep_start", 32'({b_wr_ena, b_busy, b_done, b_wr_data, b_wr_addr}),
            32'({1'b1, 1'b1, 1'b0, 9'h007, 17'd0}));
      for (int k = 1; k <= 1000; k++) begin
         @(negedge cclk);
         check("sweep_step", 32'({b_wr_ena, b_wr_data, b_wr_addr}), 32'({1'b1, 9'h007, 17'(k)}));
      end
      b_rst = 1;
      @(negedge cclk);
      b_rst = 0;
      check("abort_outputs", 32'({b_wr_ena, b_busy, b_done, b_wr_data, b_wr_addr}), 32'(0));
      nw = 0; nb = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge cclk);
         if (b_wr_ena) nw++;
         if (b_busy) nb++;
      end
      check("abort_no_writes", 32'(nw), 32'(0));
      check("abort_no_busy",   32'(nb), 32'(0));
      check("abort_done_low",  32'(b_done), 32'(0));

      // Small frame: pulsed clear runs to completion with the latched colour
      s_rst = 1;
      @(negedge cclk);
      s_rst = 0;
      @(negedge cclk);
      s_wr_cnt = 0; s_busy_cnt = 0;
      s_clr = 1; s_clr_color = 9'h007;
      @(negedge cclk);
      s_clr = 0; s_clr_color = 9'h1FF;
      repeat (SN + 20) @(negedge cclk);
      check("pulse_clear_writes", 32'(s_wr_cnt),   32'(SN));
      check("pulse_clear_busy",   32'(s_busy_cnt), 32'(SN));
      check("pulse_clear_done",   32'(s_done),     32'(1));

      // Small frame: clear_req held throughout, draw at (5,5) mid-sweep
      s_wr_cnt = 0; s_busy_cnt = 0; s_hit_cnt = 0;
      s_clr = 1; s_clr_color = 9'h0C3;
      for (int c = 0; c < SN + 40; c++) begin
         @(negedge cclk);
         s_draw_req = (c >= 100 && c < 103);
         s_x = 12'd5; s_y = 12'd5; s_color = 9'h111;
      end
      check("held_clear_writes", 32'(s_wr_cnt),   32'(SN));
      check("held_clear_busy",   32'(s_busy_cnt), 32'(SN));
      check("held_clear_hit",    32'(s_hit_cnt),  32'(1));
      check("held_clear_done",   32'(s_done),     32'(1));

      // clear_req held through reset starts a clear on the first cycle after reset
      s_rst = 1;
      @(negedge cclk);
      s_rst = 0;
      @(negedge cclk);
      check("clear_after_reset", 32'({s_busy, s_wr_ena, s_wr_addr}), 32'({1'b1, 1'b1, SA'(0)}));
      s_clr = 0; s_rst = 1;
      @(negedge cclk);
      s_rst = 0;

      // Randomised traffic on the small frame, checked cycle by cycle by the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge cclk);
         s_rst       = ($urandom_range(0, 399) == 0);
         s_draw_req  = 1'($urandom_range(0, 1));
         s_x         = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(0, SH + 1));
         s_y         = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(0, SV + 1));
         s_color     = 9'($urandom);
         s_clr_color = 9'($urandom);
         if ($urandom_range(0, 99) == 0) s_clr = ~s_clr;
      end
      @(negedge cclk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
